// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Slide-switch input conditioner. Each raw SW bit is brought
//               into the CLK100MHZ domain through a 2-flop synchronizer and
//               then filtered by a per-bit stability counter. A new level is
//               accepted only after it has differed from the current clean
//               level for DEBOUNCE_CYCLES consecutive sampled cycles. Every
//               accepted change produces a one-cycle rise or fall pulse, and
//               SW_EVENT flags any such pulse in the same cycle.
//
// Ports       : CLK100MHZ  in   system clock (100 MHz)
//               CPU_RESETN in   asynchronous active-low reset
//               SW         in   [N]  raw asynchronous switch levels
//               SW_CLEAN   out  [N]  debounced switch levels
//               SW_RISE    out  [N]  one-cycle pulse on accepted 0->1
//               SW_FALL    out  [N]  one-cycle pulse on accepted 1->0
//               SW_EVENT   out       registered OR of all rise/fall pulses
//
// Parameters  : N               number of independent switch channels
//               DEBOUNCE_CYCLES stable cycles required for acceptance (>= 2)
//               CNT_W           counter width, must hold DEBOUNCE_CYCLES-1
//
// Revision    : 1.0  initial release
// ============================================================================
module sw_debounce #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic         CLK100MHZ,
  input  logic         CPU_RESETN,
  input  logic [N-1:0] SW,
  output logic [N-1:0] SW_CLEAN,
  output logic [N-1:0] SW_RISE,
  output logic [N-1:0] SW_FALL,
  output logic         SW_EVENT
);

  // Terminal count: the cycle on which the counter would reach this value
  // with the level still different is the acceptance cycle.
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  // Synchronizer stages; only r_sync2 is ever looked at by the filter.
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  // Per-bit combinational decisions for the coming edge.
  logic [N-1:0] w_differs;
  logic [N-1:0] w_accept;
  logic [N-1:0] w_rise_nxt;
  logic [N-1:0] w_fall_nxt;

  // --------------------------------------------------------------------------
  // Per-channel stability counter and acceptance decode
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    logic [CNT_W-1:0] r_cnt;

    assign w_differs[gi]  = r_sync2[gi] ^ SW_CLEAN[gi];
    assign w_accept[gi]   = w_differs[gi] && (r_cnt == c_cnt_last);
    assign w_rise_nxt[gi] = w_accept[gi] &  r_sync2[gi];
    assign w_fall_nxt[gi] = w_accept[gi] & ~r_sync2[gi];

    // The counter is cleared both when the synchronized level agrees with
    // the clean level (bounce back) and when a change is accepted, so it
    // can never advance past c_cnt_last and never wraps.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        r_cnt <= '0;
      end else if (!w_differs[gi] || w_accept[gi]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Synchronizer, clean level and registered event outputs
  // --------------------------------------------------------------------------
  // An accepted bit always differs from its clean level, so toggling the
  // clean bit is the same as loading the synchronized value into it.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      SW_CLEAN <= '0;
      SW_RISE  <= '0;
      SW_FALL  <= '0;
      SW_EVENT <= 1'b0;
    end else begin
      r_sync1  <= SW;
      r_sync2  <= r_sync1;
      SW_CLEAN <= SW_CLEAN ^ w_accept;
      SW_RISE  <= w_rise_nxt;
      SW_FALL  <= w_fall_nxt;
      SW_EVENT <= |w_accept;
    end
  end

endmodule
`default_nettype wire

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
Input-side conditioner for the board slide switches; it is the counterpart of the switch-to-LED/RGB output logic. Each raw SW bit passes through a 2-flop synchronizer and a per-bit stability counter. The block outputs clean switch levels and one-cycle rise/fall event pulses. Downstream LED/RGB logic consumes SW_CLEAN in place of raw SW.

Parameters:
N, 4, number of switch bits handled (independent per-bit channels)
DEBOUNCE_CYCLES, 1000000, cycles a synchronized value must differ stably from SW_CLEAN before it is accepted (10 ms at 100 MHz); legal range >= 2
CNT_W, 20, stability counter width; must hold DEBOUNCE_CYCLES-1

Ports:
CLK100MHZ  input  1  system clock, 100 MHz
CPU_RESETN  input  1  asynchronous active-low reset
SW  input  N  raw asynchronous switch levels
SW_CLEAN  output  N  debounced switch levels
SW_RISE  output  N  one-cycle pulse per bit on accepted 0->1
SW_FALL  output  N  one-cycle pulse per bit on accepted 1->0
SW_EVENT  output  1  registered OR of all SW_RISE|SW_FALL bits, coincident with them

Behaviour:
- One clock: CLK100MHZ. Reset is asynchronous and active-low on CPU_RESETN. While CPU_RESETN=0: sync flops, counters, SW_CLEAN, SW_RISE, SW_FALL and SW_EVENT are all 0.
- Synchronizer per bit: s1 <= SW[i], s2 <= s1. Only s2 is used downstream. No raw SW is used combinationally.
- Counter per bit, evaluated each edge:
  - s2 == SW_CLEAN[i]: cnt <= 0; no pulse.
  - s2 != SW_CLEAN[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != SW_CLEAN[i] and cnt == DEBOUNCE_CYCLES-1: SW_CLEAN[i] <= s2, cnt <= 0, and pulse SW_RISE[i] (if s2=1) or SW_FALL[i] (if s2=0) high for exactly that next cycle.
- Latency: edge 1 is the first edge that samples a new stable SW level. SW_CLEAN updates at edge DEBOUNCE_CYCLES+2, and the pulse is high for the cycle following that edge.
- Glitch rejection: any return of s2 to SW_CLEAN before the count completes clears cnt. A bounce of fewer than DEBOUNCE_CYCLES sampled cycles never changes SW_CLEAN. The count restarts from 0 on the next difference.
- Bits are fully independent. Simultaneous acceptance on several bits in the same cycle raises all their pulses together and SW_EVENT once.
- Pulses are registered outputs: never high for more than 1 consecutive cycle per bit. A bit cannot rise and fall in the same cycle.
- SW_EVENT is registered alongside the pulses, not derived combinationally from them.
- Reset mid-count: all counts are discarded. After release, SW_CLEAN starts at 0. A switch held at 1 through reset is therefore accepted DEBOUNCE_CYCLES+2 edges after release and produces a SW_RISE pulse. This is intended: it gives consumers a start-up event.
- Counter never wraps: it saturates by construction at DEBOUNCE_CYCLES-1. CNT_W larger than needed is allowed.

Test Plan:
- Reset, then N=4, DEBOUNCE_CYCLES=4: SW=0000 held for 20 cycles -> SW_CLEAN=0000; no pulses; SW_EVENT=0 throughout.
- SW[0] 0->1 sampled at edge 1 and held -> SW_CLEAN[0]=1 after edge 6. SW_RISE[0] and SW_EVENT are high for exactly one cycle after edge 6. Other bits stay 0.
- SW[1] toggles 1,0,1,0 every cycle for 10 cycles, ending at 0 with SW_CLEAN[1]=0 -> SW_CLEAN[1] stays 0; no SW_RISE[1]. Then SW[1]=1 held with only 3 stable cycles before a drop -> still no change.
- SW[3:2] 11->00 on the same cycle after both were accepted high -> both SW_FALL bits pulse in the same cycle. SW_EVENT is high for exactly 1 cycle.
- SW=1111 held, CPU_RESETN pulsed low mid-count, asserted asynchronously between edges -> all outputs are 0 immediately. After release, SW_CLEAN=1111 at edge 6 post-release, with SW_RISE=1111 for one cycle.
- Default parameters, SW[2] 0->1 held -> SW_CLEAN[2] rises exactly 1000002 edges after first sample. There is no change at 999999 cycles of stability followed by a bounce.
